// File: rtl/modexp_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the modular-exponentiation sequencer: parameter defaults,
// FSM state encoding and the zero-pad constants for the (N+2)-bit multiplier operands.
package modexp_pkg;

    localparam int N_DEFAULT      = 512;
    localparam int ELEN_W_DEFAULT = 10;

    // The Montgomery multiplier works on N+2 bits; operands are zero-extended by PAD_W bits.
    localparam int              PAD_W    = 2;
    localparam logic [PAD_W-1:0] PAD_ZERO = '0;

    typedef enum logic [3:0] {
        IDLE,
        SQ,
        SQ_W,
        MUL,
        MUL_W,
        FIN,
        CONV,
        CONV_W,
        DONE
    } state_t;

endpackage

// File: rtl/modexp_exp_scanner.sv
`timescale 1ns/1ps
// Exponent scanner: holds the exponent left-aligned so the bit under test is always the MSB,
// plus a down-counter of remaining bits. last flags the final bit.
module modexp_exp_scanner import modexp_pkg::*; #(
    parameter int N      = N_DEFAULT,
    parameter int ELEN_W = ELEN_W_DEFAULT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load,
    input  logic              advance,
    input  logic [N-1:0]      e,
    input  logic [ELEN_W-1:0] elen,
    output logic              cur_bit,
    output logic              last
);

    localparam logic [ELEN_W:0] N_EXT = (ELEN_W+1)'(N);

    logic [N-1:0]      e_sh;
    logic [ELEN_W-1:0] cnt;
    logic [ELEN_W:0]   shamt;

    // elen is already clamped to N, so a shift of N (elen = 0) simply clears the register.
    assign shamt = N_EXT - {1'b0, elen};

    // NOTE: registers are written with <= so every flop samples pre-edge values; blocking
    // assignments here would let later statements see already-updated state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            e_sh <= '0;
            cnt  <= '0;
        end else if (load) begin
            e_sh <= e << shamt;
            cnt  <= elen;
        end else if (advance) begin
            e_sh <= {e_sh[N-2:0], 1'b0};
            cnt  <= cnt - ELEN_W'(1);
        end
    end

    assign cur_bit = e_sh[N-1];
    assign last    = (cnt == ELEN_W'(1));

endmodule

// File: rtl/modexp_ctrl.sv
`timescale 1ns/1ps
// Left-to-right square-and-multiply sequencer driving an external Montgomery multiplier.
// Define MODEXP_FINAL_CONV_EN to append the multiply-by-1 that leaves the Montgomery domain.
module modexp_ctrl import modexp_pkg::*; #(
    parameter int N      = N_DEFAULT,
    parameter int ELEN_W = ELEN_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [N-1:0]         in_x,
    input  logic [N-1:0]         in_r,
    input  logic [N-1:0]         in_e,
    input  logic [ELEN_W-1:0]    in_elen,
    input  logic [N-1:0]         in_m,
    output logic [N-1:0]         result,
    output logic                 done,
    output logic                 busy,
    output logic                 mm_start,
    output logic [N+PAD_W-1:0]   mm_a,
    output logic [N+PAD_W-1:0]   mm_b,
    output logic [N+PAD_W-1:0]   mm_m,
    input  logic [N-1:0]         mm_result,
    input  logic                 mm_done
);

`ifdef MODEXP_FINAL_CONV_EN
    localparam state_t FIN_NEXT = CONV;
`else
    localparam state_t FIN_NEXT = DONE;
`endif

    localparam logic [ELEN_W-1:0] N_ELEN = ELEN_W'(N);

    state_t            state, state_next;
    logic [N-1:0]      acc, acc_next;
    logic [N-1:0]      x_q;
    logic [ELEN_W-1:0] elen_eff;
    logic              accept;
    logic              scan_load, scan_adv;
    logic              cur_bit, last;

    assign accept   = (state == IDLE) && start;
    assign elen_eff = (in_elen > N_ELEN) ? N_ELEN : in_elen;

    modexp_exp_scanner #(.N(N), .ELEN_W(ELEN_W)) u_scanner (
        .clk     (clk),
        .resetn  (resetn),
        .load    (scan_load),
        .advance (scan_adv),
        .e       (in_e),
        .elen    (elen_eff),
        .cur_bit (cur_bit),
        .last    (last)
    );

    // FIN is resolved in the same cycle as the transition into it, so the next multiply
    // (or done) follows the last mm_done by exactly one cycle.
    // NOTE: every always_comb output gets a default before the case; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        scan_load  = 1'b0;
        scan_adv   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    scan_load  = 1'b1;
                    acc_next   = in_r;
                    state_next = (elen_eff != '0) ? SQ : FIN_NEXT;
                end
            end
            SQ:    state_next = SQ_W;
            SQ_W: begin
                if (mm_done) begin
                    acc_next = mm_result;
                    if (cur_bit) begin
                        state_next = MUL;
                    end else begin
                        scan_adv   = 1'b1;
                        state_next = last ? FIN_NEXT : SQ;
                    end
                end
            end
            MUL:   state_next = MUL_W;
            MUL_W: begin
                if (mm_done) begin
                    acc_next   = mm_result;
                    scan_adv   = 1'b1;
                    state_next = last ? FIN_NEXT : SQ;
                end
            end
            FIN:   state_next = FIN_NEXT;
`ifdef MODEXP_FINAL_CONV_EN
            CONV:  state_next = CONV_W;
            CONV_W: begin
                if (mm_done) begin
                    acc_next   = mm_result;
                    state_next = DONE;
                end
            end
`endif
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: only control and output registers sit on the async reset; there are no
    // memories here, so everything can be cleared without resetting an array.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            acc      <= '0;
            x_q      <= '0;
            result   <= '0;
            mm_start <= 1'b0;
            mm_a     <= '0;
            mm_b     <= '0;
            mm_m     <= '0;
        end else begin
            state    <= state_next;
            acc      <= acc_next;
            mm_start <= (state_next == SQ) || (state_next == MUL) || (state_next == CONV);
            if (accept) begin
                x_q  <= in_x;
                mm_m <= {PAD_ZERO, in_m};
            end
            // Operands load only on entry to an issue state, so they stay put through mm_done.
            case (state_next)
                SQ: begin
                    mm_a <= {PAD_ZERO, acc_next};
                    mm_b <= {PAD_ZERO, acc_next};
                end
                MUL: begin
                    mm_a <= {PAD_ZERO, acc_next};
                    mm_b <= {PAD_ZERO, x_q};
                end
                CONV: begin
                    mm_a <= {PAD_ZERO, acc_next};
                    mm_b <= (N+PAD_W)'(1);
                end
                default: ;
            endcase
            if (state_next == DONE) begin
                result <= acc_next;
            end
        end
    end

    assign done = (state == DONE);
    assign busy = (state != IDLE) && (state != DONE);

endmodule
